// File: rtl/spi_master_eng_if.sv
// Stream interface between the register/FIFO front end and the SPI engine.
//   tx_valid/tx_ready/tx_data : frame to transmit (right-justified)
//   rx_valid/rx_ready/rx_data : received frame (right-justified, upper bits zero)
//   rx_ovr                    : sticky overrun flag from the engine
//   ovr_clr                   : clears rx_ovr
// master modport: front end side; slave modport: engine side.
interface spi_master_eng_if #(
    parameter int unsigned DATA_W = 32
);
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_ovr;
    logic              ovr_clr;

    modport master (
        output tx_valid, tx_data, rx_ready, ovr_clr,
        input  tx_ready, rx_valid, rx_data, rx_ovr
    );

    modport slave (
        input  tx_valid, tx_data, rx_ready, ovr_clr,
        output tx_ready, rx_valid, rx_data, rx_ovr
    );
endinterface

// File: rtl/spi_master_eng.sv
// SPI master shift engine with runtime frame length (1..DATA_W bits), CS hold
// across chained frames, programmable inter-frame gap and RX overrun flag.
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   cfg_*           mode/divider/length/hold/gap, sampled only at frame accept
//   cs_v            chip-select pattern driven while selected
//   bus             tx/rx streams, rx_ovr, ovr_clr (slave modport)
//   busy            high whenever the FSM is not IDLE
//   spi_mosi/miso/sck/cs  SPI pins (spi_cs all-ones when deselected)
module spi_master_eng #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned CS_W   = 8,
    parameter int unsigned GAP_W  = 4,
    localparam int unsigned LEN_W = $clog2(DATA_W)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cfg_cpol,
    input  logic             cfg_cpha,
    input  logic             cfg_lsb_first,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_cs_hold,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic [CS_W-1:0]  cs_v,
    spi_master_eng_if.slave  bus,
    output logic             busy,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic             spi_sck,
    output logic [CS_W-1:0]  spi_cs
);
    localparam int unsigned ECNT_W = LEN_W + 2;

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;
    state_t state, state_nx;

    logic [DIV_W-1:0]  cnt, div_q;
    logic [ECNT_W-1:0] ecnt, edge_k, n2;
    logic [LEN_W-1:0]  len_q, len_c, tbit, rbit, first_idx, tx_idx_nx, rx_idx;
    logic [GAP_W-1:0]  gap_q, gcnt;
    logic [DATA_W-1:0] tx_q, rx_sh;
    logic              cpha_q, lsb_q, hold_q;
    logic              tick, accept, edge_go, hold_end, last_edge;
    logic              do_sample, do_shift, ovr_set;

    assign busy   = (state != IDLE);
    assign tick   = (cnt == '0);
    assign accept = bus.tx_valid && bus.tx_ready;

    assign len_c     = (32'(cfg_len) >= DATA_W) ? LEN_W'(DATA_W - 1) : cfg_len;
    assign first_idx = cfg_lsb_first ? '0 : len_c;

    // edge_k is the 1-based number of the SCK edge about to be produced.
    assign edge_k    = ecnt + 1'b1;
    assign n2        = {1'b0, len_q, 1'b0} + ECNT_W'(2);
    assign last_edge = (edge_k == n2);

    // CPHA=1's first leading edge only "launches" the bit already on MOSI.
    assign do_sample = cpha_q ? !edge_k[0] : edge_k[0];
    assign do_shift  = cpha_q ? (edge_k[0] && edge_k != ECNT_W'(1))
                              : (!edge_k[0] && !last_edge);

    assign tx_idx_nx = lsb_q ? (tbit + 1'b1) : (len_q - tbit - 1'b1);
    assign rx_idx    = lsb_q ? rbit : (len_q - rbit);

    assign ovr_set   = hold_end && bus.rx_valid && !bus.rx_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        bus.tx_ready = 1'b0;
        edge_go      = 1'b0;
        hold_end     = 1'b0;
        unique case (state)
            IDLE: begin
                bus.tx_ready = 1'b1;
                if (bus.tx_valid) state_nx = SETUP;
            end
            SETUP, XFER: begin
                if (tick) begin
                    edge_go  = 1'b1;
                    state_nx = last_edge ? HOLD : XFER;
                end
            end
            HOLD: begin
                if (tick) begin
                    hold_end     = 1'b1;
                    bus.tx_ready = hold_q;
                    if (hold_q && bus.tx_valid) state_nx = XFER;
                    else if (gap_q != '0)       state_nx = GAP;
                    else                        state_nx = IDLE;
                end
            end
            GAP: begin
                if (tick && gcnt == GAP_W'(1)) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt          <= '0;
            div_q        <= '0;
            ecnt         <= '0;
            len_q        <= '0;
            tbit         <= '0;
            rbit         <= '0;
            gap_q        <= '0;
            gcnt         <= '0;
            tx_q         <= '0;
            rx_sh        <= '0;
            cpha_q       <= 1'b0;
            lsb_q        <= 1'b0;
            hold_q       <= 1'b0;
            spi_sck      <= 1'b0;
            spi_mosi     <= 1'b0;
            spi_cs       <= '1;
            bus.rx_valid <= 1'b0;
            bus.rx_data  <= '0;
            bus.rx_ovr   <= 1'b0;
        end else begin
            if (state == IDLE) spi_sck <= cfg_cpol;
            else               cnt     <= tick ? div_q : cnt - 1'b1;

            if (edge_go) begin
                spi_sck <= ~spi_sck;
                ecnt    <= edge_k;
                if (do_sample) begin
                    rx_sh[rx_idx] <= spi_miso;
                    rbit          <= rbit + 1'b1;
                end
                if (do_shift) begin
                    spi_mosi <= tx_q[tx_idx_nx];
                    tbit     <= tbit + 1'b1;
                end
            end

            if (state == GAP && tick) gcnt <= gcnt - 1'b1;

            if (hold_end) begin
                bus.rx_data  <= rx_sh;
                bus.rx_valid <= 1'b1;
                if (!accept) begin
                    spi_cs <= '1;
                    gcnt   <= gap_q;
                end
            end else if (bus.rx_valid && bus.rx_ready) begin
                bus.rx_valid <= 1'b0;
            end

            if (ovr_set)          bus.rx_ovr <= 1'b1;
            else if (bus.ovr_clr) bus.rx_ovr <= 1'b0;

            // Accept from IDLE or a chained accept at the end of HOLD; the
            // chained case keeps the current CS pattern and goes straight to XFER.
            if (accept) begin
                cpha_q   <= cfg_cpha;
                lsb_q    <= cfg_lsb_first;
                len_q    <= len_c;
                div_q    <= cfg_div;
                hold_q   <= cfg_cs_hold;
                gap_q    <= cfg_gap;
                tx_q     <= bus.tx_data;
                cnt      <= cfg_div;
                ecnt     <= '0;
                tbit     <= '0;
                rbit     <= '0;
                rx_sh    <= '0;
                spi_mosi <= bus.tx_data[first_idx];
                if (state == IDLE) spi_cs <= cs_v;
            end
        end
    end
endmodule

// File: tb/tb_spi_master_eng.sv
// Self-checking bench for spi_master_eng: SPI slave model on the pins,
// scoreboard of expected rx frames popped on each rx handshake.
module tb_spi_master_eng;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DIV_W  = 8;
    localparam int unsigned CS_W   = 8;
    localparam int unsigned GAP_W  = 4;
    localparam int unsigned LEN_W  = $clog2(DATA_W);
    localparam logic [CS_W-1:0] CS_OFF = '1;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb_first = 1'b0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_cs_hold = 1'b0;
    logic [GAP_W-1:0] cfg_gap = '0;
    logic [CS_W-1:0]  cs_v = 8'hFE;
    logic             busy, spi_mosi, spi_miso, spi_sck;
    logic [CS_W-1:0]  spi_cs;

    spi_master_eng_if #(.DATA_W(DATA_W)) bus ();

    spi_master_eng #(.DATA_W(DATA_W), .DIV_W(DIV_W), .CS_W(CS_W), .GAP_W(GAP_W)) dut (
        .clk(clk), .rstn(rstn), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .cfg_lsb_first(cfg_lsb_first), .cfg_div(cfg_div), .cfg_len(cfg_len),
        .cfg_cs_hold(cfg_cs_hold), .cfg_gap(cfg_gap), .cs_v(cs_v), .bus(bus),
        .busy(busy), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_sck(spi_sck),
        .spi_cs(spi_cs)
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0, n_pass = 0;
    logic [DATA_W-1:0] sb[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- SPI slave model ----------------
    logic              s_cpha = 1'b0, s_lsb = 1'b0, loopback = 1'b0, s_miso = 1'b0;
    int unsigned       s_len = 7, s_k = 0;
    logic [DATA_W-1:0] s_word = '0, s_seq = '0, s_last_seq = '0;

    assign spi_miso = loopback ? spi_mosi : s_miso;

    function automatic int unsigned sidx(input int unsigned j);
        return s_lsb ? j : s_len - j;
    endfunction

    always @(spi_cs) begin
        if (spi_cs != CS_OFF) begin
            s_k   = 0;
            s_seq = '0;
            if (!s_cpha) s_miso = s_word[sidx(0)];
        end
    end

    always @(spi_sck) begin
        if (spi_cs != CS_OFF) begin
            s_k++;
            if (s_cpha ? (s_k % 2 == 0) : (s_k % 2 == 1))
                s_seq = {s_seq[DATA_W-2:0], spi_mosi};
            else if (s_cpha)
                s_miso = s_word[sidx((s_k - 1) / 2)];
            else if (s_k / 2 <= s_len)
                s_miso = s_word[sidx(s_k / 2)];
            if (s_k == 2 * (s_len + 1)) begin
                s_last_seq = s_seq;
                s_seq      = '0;
                s_k        = 0;
                if (!s_cpha) s_miso = s_word[sidx(0)];
            end
        end
    end

    // ---------------- pin / handshake monitor ----------------
    bit          cs_low = 1'b0;
    logic        sck_prev = 1'b0;
    int unsigned lo_cnt = 0, hi_cnt = 0, cs_low_len = 0, last_gap = 0;
    int unsigned sck_edges = 0, cs_rises = 0, rx_hs = 0;

    always @(negedge clk) begin
        if (cs_low) begin
            if (spi_cs == CS_OFF) begin
                cs_low     = 1'b0;
                cs_low_len = lo_cnt;
                cs_rises++;
                hi_cnt     = 1;
            end else begin
                lo_cnt++;
                if (spi_sck != sck_prev) sck_edges++;
            end
        end else if (spi_cs != CS_OFF) begin
            cs_low    = 1'b1;
            lo_cnt    = 1;
            last_gap  = hi_cnt;
            sck_edges = 0;
        end else begin
            hi_cnt++;
        end
        sck_prev = spi_sck;

        if (rstn && bus.rx_valid && bus.rx_ready) begin
            rx_hs++;
            if (sb.size() == 0) check("rx_unexpected", bus.rx_valid, 1'b0);
            else                check("rx_data", bus.rx_data, sb.pop_front());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic setup(input logic cpol, input logic cpha, input logic lsb,
                         input int unsigned div, input int unsigned len, input logic hold,
                         input int unsigned gap, input logic [DATA_W-1:0] word, input logic lb);
        cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb_first = lsb;
        cfg_div = DIV_W'(div); cfg_len = LEN_W'(len); cfg_cs_hold = hold;
        cfg_gap = GAP_W'(gap);
        s_cpha = cpha; s_lsb = lsb; s_len = len; s_word = word; loopback = lb;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp, input bit push);
        int unsigned n = 0;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        if (push) sb.push_back(exp);
        while (!bus.tx_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.tx_ready) check("tx_accept_timeout", bus.tx_ready, 1'b1);
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        @(negedge clk);
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", busy, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        bus.tx_valid = 1'b0; bus.tx_data = '0; bus.rx_ready = 1'b1; bus.ovr_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("rst_sck", spi_sck, 1'b0);
        check("rst_mosi", spi_mosi, 1'b0);
        check("rst_cs", spi_cs, CS_OFF);
        check("rst_rx_valid", bus.rx_valid, 1'b0);
        check("rst_rx_data", bus.rx_data, '0);
        check("rst_rx_ovr", bus.rx_ovr, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_ready", bus.tx_ready, 1'b1);

        // 1) mode 0, div=1, 8 bits, loopback
        setup(0, 0, 0, 1, 7, 0, 0, '0, 1);
        send(32'hA5, 32'hA5, 1);
        wait_idle();
        check("t1_cs_low_cycles", cs_low_len, 34);
        check("t1_sck_pulses", sck_edges / 2, 8);
        check("t1_mosi_seq", s_last_seq, 32'hA5);

        // 2) all four modes, 16 bits, slave returns 0xBEEF
        for (int m = 0; m < 4; m++) begin
            logic cp, ch;
            cp = m[1];
            ch = m[0];
            setup(cp, ch, 0, 2, 15, 0, 0, 32'hBEEF, 0);
            repeat (2) @(negedge clk);
            send(32'h1234, 32'hBEEF, 1);
            wait_idle();
            check("t2_mosi_seq", s_last_seq, 32'h1234);
            check("t2_sck_idle", spi_sck, cp);
            check("t2_sck_pulses", sck_edges / 2, 16);
        end

        // 3) LSB-first, 4 bits; upper tx bits must be ignored
        setup(0, 0, 1, 0, 3, 0, 0, 32'hA, 0);
        repeat (2) @(negedge clk);
        send(32'hFFFF_FFF6, 32'hA, 1);
        wait_idle();
        check("t3_mosi_0110", s_last_seq, 32'h6);

        // 4a) cs_hold chain of three frames
        setup(1, 1, 0, 1, 7, 1, 0, '0, 1);
        repeat (2) @(negedge clk);
        cs_rises = 0; rx_hs = 0;
        send(32'h11, 32'h11, 1);
        send(32'h22, 32'h22, 1);
        cfg_cs_hold = 1'b0;
        send(32'h33, 32'h33, 1);
        wait_idle();
        check("t4_cs_rises_chain", cs_rises, 1);
        check("t4_rx_pulses", rx_hs, 3);

        // 4b) no hold, gap=2: GAP half-periods plus the IDLE accept cycle
        setup(0, 0, 0, 1, 7, 0, 2, '0, 1);
        repeat (2) @(negedge clk);
        cs_rises = 0;
        send(32'h44, 32'h44, 1);
        send(32'h55, 32'h55, 1);
        wait_idle();
        check("t4_gap_cycles", last_gap, 2 * (1 + 1) + 1);
        check("t4_cs_rises_gap", cs_rises, 2);

        // 5) overrun
        bus.rx_ready = 1'b0;
        send(32'h5A, 32'h5A, 0);
        send(32'hC3, 32'hC3, 1);
        wait_idle();
        check("t5_rx_ovr_set", bus.rx_ovr, 1'b1);
        check("t5_rx_valid_held", bus.rx_valid, 1'b1);
        bus.ovr_clr = 1'b1;
        @(negedge clk);
        bus.ovr_clr = 1'b0;
        @(negedge clk);
        check("t5_rx_ovr_clr", bus.rx_ovr, 1'b0);
        bus.rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_rx_valid_drop", bus.rx_valid, 1'b0);

        // 6) reset mid-frame
        setup(0, 0, 0, 1, 7, 0, 0, '0, 1);
        send(32'h96, 32'h96, 0);
        n = 0;
        while (s_k < 9 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (s_k < 9) check("t6_bit5_timeout", s_k >= 9, 1'b1);
        #1 rstn = 1'b0;
        #1;
        check("t6_rst_cs", spi_cs, CS_OFF);
        check("t6_rst_sck", spi_sck, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        check("t6_no_rx_valid", bus.rx_valid, 1'b0);
        @(posedge clk);
        #1 rstn = 1'b1;
        send(32'h69, 32'h69, 1);
        wait_idle();
        check("t6_mosi_seq", s_last_seq, 32'h69);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
